// File: rtl/mem_stage.sv
// Memory stage of the pipeline: issues data SRAM requests for loads and stores
// on acceptance from EX, holds the result, and extracts load data for WB.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,

    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rt_value,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_mem_type,
    input  logic        ex_reg_we,
    input  logic [4:0]  ex_reg_waddr,
    input  logic        mem_flush,
    output logic        mem_allowin,

    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,

    input  logic        wb_allowin,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_reg_we,
    output logic [4:0]  wb_reg_waddr,
    output logic [31:0] wb_reg_wdata,
    output logic        wb_addr_err,
    output logic [4:0]  mem_dest
);

    localparam logic [2:0] MT_BYTE  = 3'b000;
    localparam logic [2:0] MT_BYTEU = 3'b001;
    localparam logic [2:0] MT_HALF  = 3'b010;
    localparam logic [2:0] MT_HALFU = 3'b011;

    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_alu_result;
    logic        mem_read;
    logic [2:0]  mem_type;
    logic        mem_reg_we;
    logic [4:0]  mem_reg_waddr;
    logic        mem_addr_err;

    logic        captured;
    logic [31:0] hold_data;

    logic        accept;
    logic        ex_is_mem;
    logic        ex_addr_err;

    assign mem_allowin = resetn & (~mem_valid | wb_allowin) & ~mem_flush;
    assign accept      = ex_valid & mem_allowin;
    assign ex_is_mem   = ex_mem_read | ex_mem_write;

    always_comb begin
        ex_addr_err = 1'b0;
        if (ex_is_mem) begin
            if (ex_mem_type[2])
                ex_addr_err = (ex_alu_result[1:0] != 2'b00);
            else if (ex_mem_type[1])
                ex_addr_err = ex_alu_result[0];
        end
    end

    // The request goes out straight from the EX inputs in the accept cycle.
    assign data_sram_en   = accept & ex_is_mem & ~ex_addr_err;
    assign data_sram_addr = {ex_alu_result[31:2], 2'b00};

    always_comb begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = ex_rt_value;
        if (ex_mem_type[2]) begin
            data_sram_wdata = ex_rt_value;
        end else if (ex_mem_type[1]) begin
            data_sram_wdata = {2{ex_rt_value[15:0]}};
        end else begin
            data_sram_wdata = {4{ex_rt_value[7:0]}};
        end
        if (data_sram_en && ex_mem_write) begin
            if (ex_mem_type[2])
                data_sram_wen = 4'b1111;
            else if (ex_mem_type[1])
                data_sram_wen = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            else
                data_sram_wen = 4'b0001 << ex_alu_result[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid      <= 1'b0;
            mem_pc         <= 32'h0;
            mem_alu_result <= 32'h0;
            mem_read       <= 1'b0;
            mem_type       <= 3'b000;
            mem_reg_we     <= 1'b0;
            mem_reg_waddr  <= 5'd0;
            mem_addr_err   <= 1'b0;
            captured       <= 1'b0;
            hold_data      <= 32'h0;
        end else begin
            if (mem_flush) begin
                mem_valid <= 1'b0;
            end else if (accept) begin
                mem_valid      <= 1'b1;
                mem_pc         <= ex_pc;
                mem_alu_result <= ex_alu_result;
                mem_read       <= ex_mem_read;
                mem_type       <= ex_mem_type;
                mem_reg_we     <= ex_reg_we;
                mem_reg_waddr  <= ex_reg_waddr;
                mem_addr_err   <= ex_addr_err;
            end else if (mem_allowin) begin
                mem_valid <= 1'b0;
            end

            // SRAM output is only valid for one cycle; keep a copy for stalls.
            if (accept) begin
                captured <= 1'b0;
            end else if (mem_valid && !captured) begin
                captured  <= 1'b1;
                hold_data <= data_sram_rdata;
            end
        end
    end

    logic [31:0] load_word;
    logic [31:0] shifted_b;
    logic [31:0] shifted_h;
    logic [31:0] load_value;

    always_comb begin
        load_word = captured ? hold_data : data_sram_rdata;
        shifted_b = load_word >> {mem_alu_result[1:0], 3'b000};
        shifted_h = load_word >> {mem_alu_result[1], 4'b0000};
        case (mem_type)
            MT_BYTE:  load_value = {{24{shifted_b[7]}}, shifted_b[7:0]};
            MT_BYTEU: load_value = {24'h0, shifted_b[7:0]};
            MT_HALF:  load_value = {{16{shifted_h[15]}}, shifted_h[15:0]};
            MT_HALFU: load_value = {16'h0, shifted_h[15:0]};
            default:  load_value = load_word;
        endcase
    end

    assign wb_valid     = mem_valid;
    assign wb_pc        = mem_pc;
    assign wb_reg_we    = mem_valid & mem_reg_we & ~mem_addr_err;
    assign wb_reg_waddr = mem_reg_waddr;
    assign wb_reg_wdata = mem_read ? load_value : mem_alu_result;
    assign wb_addr_err  = mem_valid & mem_addr_err;
    assign mem_dest     = (mem_valid && mem_reg_we) ? mem_reg_waddr : 5'd0;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 ex_valid  in  1  EX holds a valid instruction for MEM.
REQ-004 ex_pc  in  32  PC of EX instruction.
REQ-005 ex_alu_result  in  32  effective address, or result for non-memory ops.
REQ-006 ex_rt_value  in  32  store data (rt).
REQ-007 ex_mem_read / ex_mem_write  in  1 each  load / store; never both set.
REQ-008 ex_mem_type  in  3  000 byte, 001 byte-unsigned, 010 half, 011 half-unsigned, 100 word; unsigned codes apply to loads only.
REQ-009 ex_reg_we  in  1 / ex_reg_waddr  in  5  register write enable and destination.
REQ-010 mem_flush  in  1  discard the instruction held in MEM.
REQ-011 mem_allowin  out  1  MEM accepts from EX this cycle.
REQ-012 data_sram_en  out  1 / data_sram_wen  out  4 / data_sram_addr  out  32 / data_sram_wdata  out  32 / data_sram_rdata  in  32: synchronous SRAM, read data valid the cycle after the enable edge.
REQ-013 wb_allowin  in  1  WB accepts from MEM this cycle.
REQ-014 wb_valid  out  1 / wb_pc  out  32 / wb_reg_we  out  1 / wb_reg_waddr  out  5 / wb_reg_wdata  out  32  result presented to WB.
REQ-015 wb_addr_err  out  1  held instruction is a misaligned access.
REQ-016 mem_dest  out  5  ex_reg_waddr of held instruction when mem_valid and reg_we are both set, else 0 (for hazard detection).

Function
REQ-017 mem_allowin = resetn & (~mem_valid | wb_allowin) & ~mem_flush; accept = ex_valid & mem_allowin.
REQ-018 On accept, the MEM register captures all ex_* fields and mem_valid is set to 1; when mem_allowin is 1 without accept, mem_valid clears to 0; otherwise the register holds.
REQ-019 mem_flush = 1 clears mem_valid at the next edge and overrides every other update.
REQ-020 Alignment error: half access with addr[0]=1, or word access with addr[1:0]!=00; the error is computed at accept and registered.
REQ-021 data_sram_en = accept & (ex_mem_read | ex_mem_write) & ~alignment error; the request is issued from the ex_* inputs in the accept cycle.
REQ-022 data_sram_addr = {ex_alu_result[31:2], 2'b00}.
REQ-023 data_sram_wen = 0 unless data_sram_en & ex_mem_write; byte = 0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-024 data_sram_wdata: byte = four copies of rt[7:0]; half = two copies of rt[15:0]; word = rt.
REQ-025 Load data hold: in the first cycle after accept, data_sram_rdata is used and also copied into a hold register with a captured flag set; while MEM stays stalled, the hold register is used; the flag clears on the next accept or on reset.
REQ-026 Load extraction: shift the word right by 8*addr[1:0] (byte) or 16*addr[1] (half), then sign-extend or zero-extend per mem_type.
REQ-027 wb_reg_wdata = extracted load data if mem_read, else the registered alu_result.
REQ-028 wb_valid = mem_valid; wb_reg_we = mem_valid & reg_we & ~addr_err; wb_addr_err = mem_valid & addr_err.
REQ-029 Back-to-back loads with wb_allowin = 1 sustain one instruction per cycle with no bubble.

Reset
REQ-030 At a rising edge with resetn = 0: mem_valid = 0, captured flag = 0, all MEM register fields = 0.
REQ-031 While resetn = 0: mem_allowin, data_sram_en, data_sram_wen, wb_valid and wb_reg_we are all 0.
REQ-032 A reset while an access is in flight drops that instruction; its SRAM read data is ignored.

Verification
REQ-033 LB at addr 0x103, SRAM word 0x80FF_1234 -> en = 1 and addr = 0x100 in the accept cycle; next cycle wb_reg_wdata = 0xFFFF_FF80 with wb_reg_we = 1.
REQ-034 SH at addr 0x22, rt = 0x0000_ABCD -> wen = 1100 and wdata = 0xABCD_ABCD; wb_reg_we = 0.
REQ-035 LW at addr 0x06 -> data_sram_en = 0; next cycle wb_addr_err = 1 and wb_reg_we = 0.
REQ-036 LHU at addr 0x02 with word 0x9876_0000, and wb_allowin = 0 for 3 cycles while the SRAM output changes -> wb_reg_wdata stays 0x0000_9876 for all cycles; mem_allowin = 0 while stalled.
REQ-037 Flush asserted while a valid instruction is held and ex_valid = 1 -> next cycle wb_valid = 0 and no SRAM enable was issued in the flush cycle.
REQ-038 resetn low for one edge mid-stall -> mem_valid = 0 and wb_valid = 0; mem_allowin = 1 once resetn returns high.
